mult_pipe: RTL and testbench

Parametrised, elastic, multi-stage integer multiplier for the CVA6 execute stage. It supersedes the fixed single-register multiplier with four additions: configurable pipeline depth, valid/ready backpressure on both sides, per-thread flush of in-flight operations, and an optional carry-less multiply datapath. It sits behind the issue stage next to the ALU/divider and returns results to the writeback arbiter tagged with transaction and thread ID.

---
 rtl/mult_pipe_pkg.sv | 22 ++
 rtl/mult_pipe_slice.sv | 52 +++++
 rtl/mult_pipe.sv | 166 ++++++++++++++++
 tb/tb_mult_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared operation encoding and limits for the pipelined multiplier.
package mult_pipe_pkg;

    localparam int unsigned MULT_PIPE_MAX_STAGES = 4;

    // Subset of the core's fu_op encoding that this unit executes.
    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHU  = 4'd2,
        MULHSU = 4'd3,
        MULW   = 4'd4,
        CLMUL  = 4'd5,
        CLMULH = 4'd6,
        CLMULR = 4'd7
    } fu_op_e;

    function automatic logic op_legal(logic [3:0] op);
        return op <= CLMULR;
    endfunction

endpackage

// File: rtl/mult_pipe_slice.sv
// One elastic register stage of mult_pipe: valid bit, payload and thread tag, with
// a per-thread kill applied to whatever the stage holds after the clock edge.
module mult_pipe_slice
    import mult_pipe_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter int unsigned TidWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [Width-1:0]    data_i,
    input  logic [TidWidth-1:0] thread_i,
    input  logic                flush_i,
    input  logic [TidWidth-1:0] flush_thread_i,
    output logic                valid_o,
    output logic [Width-1:0]    data_o,
    output logic [TidWidth-1:0] thread_o
);

    logic                valid_d, valid_q;
    logic [Width-1:0]    data_q;
    logic [TidWidth-1:0] thread_q;

    always_comb begin
        if (en_i) begin
            valid_d = valid_i & ~(flush_i & (thread_i == flush_thread_i));
        end else begin
            valid_d = valid_q & ~(flush_i & (thread_q == flush_thread_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            thread_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (en_i) begin
                data_q   <= data_i;
                thread_q <= thread_i;
            end
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign thread_o = thread_q;

endmodule

// File: rtl/mult_pipe.sv
// Elastic NUM_STAGES-deep integer multiplier with per-thread flush.
// Define MULT_PIPE_CLMUL_EN to build the carry-less multiply datapath.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned NUM_THREADS_LOG = 1,
    parameter int unsigned NUM_STAGES      = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [3:0]                 operation_i,
    input  logic [XLEN-1:0]            operand_a_i,
    input  logic [XLEN-1:0]            operand_b_i,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [NUM_THREADS_LOG-1:0] thread_id_i,
    input  logic                       flush_i,
    input  logic [NUM_THREADS_LOG-1:0] flush_thread_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [XLEN-1:0]            result_o,
    output logic [TRANS_ID_BITS-1:0]   trans_id_o,
    output logic [NUM_THREADS_LOG-1:0] thread_id_o,
    output logic                       busy_o
);

    if (NUM_STAGES == 0 || NUM_STAGES > MULT_PIPE_MAX_STAGES) begin : g_bad_cfg
        $error("mult_pipe: NUM_STAGES out of range");
    end

    localparam int unsigned ProdW = 2 * XLEN;
`ifdef MULT_PIPE_CLMUL_EN
    localparam int unsigned ClW = XLEN;
`else
    localparam int unsigned ClW = 0;
`endif
    localparam int unsigned PayW = ProdW + ClW + 4 + TRANS_ID_BITS;

    // Stage 0: signed (XLEN+1)x(XLEN+1) product with per-op sign extension.
    logic                      sign_a, sign_b;
    logic signed [XLEN:0]      opa_ext, opb_ext;
    logic signed [2*XLEN+1:0]  opa_w, opb_w, prod;
    logic [1:0]                unused_prod;
    logic [PayW-1:0]           pay_in;

    always_comb begin
        sign_a  = (operation_i == MULH) || (operation_i == MULHSU);
        sign_b  = (operation_i == MULH);
        opa_ext = {sign_a & operand_a_i[XLEN-1], operand_a_i};
        opb_ext = {sign_b & operand_b_i[XLEN-1], operand_b_i};
        opa_w   = (2*XLEN+2)'(opa_ext);
        opb_w   = (2*XLEN+2)'(opb_ext);
        prod    = opa_w * opb_w;
    end
    assign unused_prod = prod[2*XLEN+1:2*XLEN];

`ifdef MULT_PIPE_CLMUL_EN
    // CLMULR/CLMULH reuse the plain clmul array on bit-reversed operands.
    logic            clmul_rev;
    logic [XLEN-1:0] cl_a, cl_b, cl_raw, cl_res;

    always_comb begin
        clmul_rev = (operation_i == CLMULH) || (operation_i == CLMULR);
        for (int i = 0; i < XLEN; i++) begin
            cl_a[i] = clmul_rev ? operand_a_i[XLEN-1-i] : operand_a_i[i];
            cl_b[i] = clmul_rev ? operand_b_i[XLEN-1-i] : operand_b_i[i];
        end
        cl_raw = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (cl_b[i]) cl_raw = cl_raw ^ (cl_a << i);
        end
        for (int i = 0; i < XLEN; i++) begin
            cl_res[i] = clmul_rev ? cl_raw[XLEN-1-i] : cl_raw[i];
        end
    end

    assign pay_in = {prod[ProdW-1:0], cl_res, operation_i, trans_id_i};
`else
    assign pay_in = {prod[ProdW-1:0], operation_i, trans_id_i};
`endif

    logic [NUM_STAGES-1:0]      stage_valid, stage_en;
    logic [PayW-1:0]            stage_data   [NUM_STAGES];
    logic [NUM_THREADS_LOG-1:0] stage_thread [NUM_STAGES];
    logic                       downstream_en;

    // A stage takes new data when it is empty or its content moves on.
    always_comb begin
        downstream_en = ready_i;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            downstream_en = ~stage_valid[k] | downstream_en;
            stage_en[k]   = downstream_en;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                       v_in;
        logic [PayW-1:0]            d_in;
        logic [NUM_THREADS_LOG-1:0] t_in;

        if (k == 0) begin : g_head
            assign v_in = valid_i & op_legal(operation_i);
            assign d_in = pay_in;
            assign t_in = thread_id_i;
        end else begin : g_body
            assign v_in = stage_valid[k-1];
            assign d_in = stage_data[k-1];
            assign t_in = stage_thread[k-1];
        end

        mult_pipe_slice #(
            .Width    (PayW),
            .TidWidth (NUM_THREADS_LOG)
        ) u_slice (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .en_i           (stage_en[k]),
            .valid_i        (v_in),
            .data_i         (d_in),
            .thread_i       (t_in),
            .flush_i        (flush_i),
            .flush_thread_i (flush_thread_i),
            .valid_o        (stage_valid[k]),
            .data_o         (stage_data[k]),
            .thread_o       (stage_thread[k])
        );
    end

    logic [ProdW-1:0]         prod_q;
    logic [3:0]               op_q;
    logic [TRANS_ID_BITS-1:0] tid_q;
`ifdef MULT_PIPE_CLMUL_EN
    logic [XLEN-1:0]          cl_q;
    assign {prod_q, cl_q, op_q, tid_q} = stage_data[NUM_STAGES-1];
`else
    assign {prod_q, op_q, tid_q} = stage_data[NUM_STAGES-1];
`endif

    always_comb begin
        result_o = '0;
        case (op_q)
            MUL:                 result_o = prod_q[XLEN-1:0];
            MULH, MULHU, MULHSU: result_o = prod_q[ProdW-1:XLEN];
            MULW:                result_o = (XLEN == 64) ? XLEN'($signed(prod_q[31:0]))
                                                         : prod_q[XLEN-1:0];
`ifdef MULT_PIPE_CLMUL_EN
            CLMUL, CLMULR:       result_o = cl_q;
            CLMULH:              result_o = cl_q >> 1;
`else
            // Still retired so the scoreboard entry completes.
            CLMUL, CLMULH, CLMULR: result_o = '0;
`endif
            default:             result_o = '0;
        endcase
    end

    assign ready_o     = stage_en[0];
    assign valid_o     = stage_valid[NUM_STAGES-1];
    assign trans_id_o  = tid_q;
    assign thread_id_o = stage_thread[NUM_STAGES-1];
    assign busy_o      = |stage_valid;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed self-checking bench for mult_pipe (XLEN=64, NUM_STAGES=3).
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [3:0]  operation_i, trans_id_i, trans_id_o;
    logic [63:0] operand_a_i, operand_b_i, result_o;
    logic        thread_id_i, flush_thread_i, thread_id_o;

    int checks = 0;
    int errors = 0;
    int sent, got, seen;

    mult_pipe #(
        .XLEN            (64),
        .TRANS_ID_BITS   (4),
        .NUM_THREADS_LOG (1),
        .NUM_STAGES      (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .operation_i    (operation_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .trans_id_i     (trans_id_i),
        .thread_id_i    (thread_id_i),
        .flush_i        (flush_i),
        .flush_thread_i (flush_thread_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .result_o       (result_o),
        .trans_id_o     (trans_id_o),
        .thread_id_o    (thread_id_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tid, input logic thr);
        valid_i     = 1'b1;
        operation_i = op;
        operand_a_i = a;
        operand_b_i = b;
        trans_id_i  = tid;
        thread_id_i = thr;
    endtask

    task automatic idle();
        valid_i     = 1'b0;
        operation_i = 4'd0;
        operand_a_i = '0;
        operand_b_i = '0;
        trans_id_i  = '0;
        thread_id_i = 1'b0;
    endtask

    // One op through an empty pipe with ready_i high; result due NUM_STAGES cycles later.
    task automatic single(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tid, input logic [63:0] exp);
        drive(op, a, b, tid, 1'b0);
        step();
        idle();
        step();
        step();
        sample();
        check({name, " valid"}, 64'(valid_o), 64'd1);
        check({name, " result"}, result_o, exp);
        check({name, " trans_id"}, 64'(trans_id_o), 64'(tid));
        step();
    endtask

    initial begin
        rst_ni         = 1'b0;
        ready_i        = 1'b1;
        flush_i        = 1'b0;
        flush_thread_i = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        sample();
        check("rst valid_o", 64'(valid_o), 64'd0);
        check("rst busy_o", 64'(busy_o), 64'd0);
        check("rst ready_o", 64'(ready_o), 64'd1);
        check("rst result_o", result_o, 64'd0);
        check("rst trans_id_o", 64'(trans_id_o), 64'd0);
        check("rst thread_id_o", 64'(thread_id_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // Latency: MUL 3x5 tag 7
        drive(MUL, 64'd3, 64'd5, 4'd7, 1'b0);
        sample();
        check("lat ready_o", 64'(ready_o), 64'd1);
        step();
        idle();
        sample();
        check("lat busy c1", 64'(busy_o), 64'd1);
        check("lat valid c1", 64'(valid_o), 64'd0);
        step();
        sample();
        check("lat valid c2", 64'(valid_o), 64'd0);
        step();
        sample();
        check("lat valid c3", 64'(valid_o), 64'd1);
        check("lat result", result_o, 64'd15);
        check("lat trans_id", 64'(trans_id_o), 64'd7);
        step();
        sample();
        check("lat valid after", 64'(valid_o), 64'd0);
        check("lat busy after", 64'(busy_o), 64'd0);
        step();

        single("mulhu", MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1,
               64'hFFFF_FFFF_FFFF_FFFE);
        single("mulh", MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 64'd0);
        single("mulhsu", MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'd3,
               64'hFFFF_FFFF_FFFF_FFFF);
        single("mulw", MULW, 64'h7FFF_FFFF, 64'd2, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        single("mul wrap", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef MULT_PIPE_CLMUL_EN
        single("clmul", CLMUL, 64'd3, 64'd3, 4'd6, 64'd5);
        single("clmulr hi", CLMULR, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd8,
               64'h8000_0000_0000_0000);
        single("clmulh hi", CLMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd9,
               64'h4000_0000_0000_0000);
`else
        single("clmul", CLMUL, 64'd3, 64'd3, 4'd6, 64'd0);
        single("clmulr hi", CLMULR, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd8,
               64'd0);
        single("clmulh hi", CLMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd9,
               64'd0);
`endif
        single("clmulr 1x1", CLMULR, 64'd1, 64'd1, 4'd10, 64'd0);

        // Illegal op is consumed without a result
        drive(4'hF, 64'd3, 64'd3, 4'd11, 1'b0);
        step();
        idle();
        sample();
        check("illegal busy", 64'(busy_o), 64'd0);
        check("illegal ready", 64'(ready_o), 64'd1);
        seen = 0;
        repeat (4) begin
            step();
            sample();
            if (valid_o) seen = 1;
        end
        check("illegal no output", 64'(seen), 64'd0);
        step();

        // Backpressure: capacity 3, results held while stalled, then drained in order
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(MUL, 64'(i + 1), 64'd10, 4'(i + 1), 1'b0);
            sample();
            check("bp accept ready", 64'(ready_o), 64'd1);
            step();
        end
        drive(MUL, 64'd4, 64'd10, 4'd4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sample();
            check("bp full ready", 64'(ready_o), 64'd0);
            check("bp hold valid", 64'(valid_o), 64'd1);
            check("bp hold result", result_o, 64'd10);
            check("bp hold trans", 64'(trans_id_o), 64'd1);
            step();
        end
        sent = 3;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            ready_i = (cyc % 2 == 0);
            sample();
            if (valid_o) begin
                check("bp drain result", result_o, 64'(10 * (got + 1)));
                check("bp drain trans", 64'(trans_id_o), 64'(got + 1));
                if (ready_i) got++;
            end
            if (valid_i && ready_o) sent++;
            step();
            if (sent < 5) drive(MUL, 64'(sent + 1), 64'd10, 4'(sent + 1), 1'b0);
            else idle();
        end
        check("bp drained count", 64'(got), 64'd5);
        ready_i = 1'b1;
        idle();
        step();
        sample();
        check("bp busy after", 64'(busy_o), 64'd0);
        step();

        // Flush thread 1 with A(t0) B(t1) C(t0) in flight and D(t1) offered
        drive(MUL, 64'd2, 64'd3, 4'd1, 1'b0);
        step();
        drive(MUL, 64'd10, 64'd10, 4'd2, 1'b1);
        step();
        drive(MUL, 64'd4, 64'd5, 4'd3, 1'b0);
        step();
        drive(MUL, 64'd7, 64'd7, 4'd4, 1'b1);
        flush_i        = 1'b1;
        flush_thread_i = 1'b1;
        sample();
        check("fl A valid", 64'(valid_o), 64'd1);
        check("fl A result", result_o, 64'd6);
        check("fl A trans", 64'(trans_id_o), 64'd1);
        check("fl A thread", 64'(thread_id_o), 64'd0);
        step();
        idle();
        flush_i        = 1'b0;
        flush_thread_i = 1'b0;
        sample();
        check("fl B dropped", 64'(valid_o), 64'd0);
        check("fl busy", 64'(busy_o), 64'd1);
        step();
        sample();
        check("fl C valid", 64'(valid_o), 64'd1);
        check("fl C result", result_o, 64'd20);
        check("fl C trans", 64'(trans_id_o), 64'd3);
        check("fl C thread", 64'(thread_id_o), 64'd0);
        step();
        sample();
        check("fl D dropped", 64'(valid_o), 64'd0);
        check("fl busy end", 64'(busy_o), 64'd0);
        step();

        // Reset with two ops in flight
        ready_i = 1'b0;
        drive(MUL, 64'd6, 64'd7, 4'd5, 1'b0);
        step();
        drive(MUL, 64'd8, 64'd9, 4'd6, 1'b1);
        step();
        idle();
        step();
        sample();
        check("rst2 pre valid", 64'(valid_o), 64'd1);
        check("rst2 pre result", result_o, 64'd42);
        #1 rst_ni = 1'b0;
        #1;
        check("rst2 valid", 64'(valid_o), 64'd0);
        check("rst2 busy", 64'(busy_o), 64'd0);
        check("rst2 ready", 64'(ready_o), 64'd1);
        sample();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        seen    = 0;
        repeat (6) begin
            step();
            sample();
            if (valid_o) seen = 1;
        end
        check("rst2 no output", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
